// File: rtl/race_enemy_scheduler.sv
// rtl/race_enemy_scheduler.sv - enemy car spawn, move, exit, speed ramp and collision engine
//
// Owns NUM_ENEMIES enemy slots spread over LANE_COUNT lanes. Cars spawn into
// LFSR-chosen lanes, move down one pixel per move period, leave at Y_END
// (scoring a point), and are checked against the player car every cycle.
// A hit latches game_over, which freezes the whole engine until reset.
//
// Ports:
//   clk_i           system clock
//   reset_i         synchronous active-high reset
//   player_lane_i   lane of the player car (clamped to LANE_COUNT-1)
//   enemy_x_o       x of slot i in bits [10i+9:10i]
//   enemy_y_o       y of slot i in bits [10i+9:10i]
//   enemy_active_o  bit i set while slot i is on screen
//   collision_o     one-cycle pulse on the first hit
//   game_over_o     latched after a hit
//   score_o         enemies that reached Y_END (saturating)
//   move_div_o      current move divider
module race_enemy_scheduler #(
  parameter int         NUM_ENEMIES   = 4,
  parameter int         LANE_COUNT    = 3,
  parameter int         LANE_X0       = 197,
  parameter int         LANE_PITCH    = 82,
  parameter int         CAR_H         = 121,
  parameter int         PLAYER_Y      = 357,
  parameter int         Y_END         = 600,
  parameter int         SPAWN_DIV     = 2500000,
  parameter int         MOVE_DIV_INIT = 100000,
  parameter int         MOVE_DIV_MIN  = 20000,
  parameter int         MOVE_DIV_STEP = 1000,
  parameter int         RAMP_SPAWNS   = 50,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [1:0]                player_lane_i,
  output logic [10*NUM_ENEMIES-1:0] enemy_x_o,
  output logic [10*NUM_ENEMIES-1:0] enemy_y_o,
  output logic [NUM_ENEMIES-1:0]    enemy_active_o,
  output logic                      collision_o,
  output logic                      game_over_o,
  output logic [15:0]               score_o,
  output logic [24:0]               move_div_o
);
  localparam int N = NUM_ENEMIES;

  logic [9:0]   x_q [N];
  logic [9:0]   x_d [N];
  logic [9:0]   y_q [N];
  logic [9:0]   y_d [N];
  logic [N-1:0] active_q, active_d;
  logic         collision_q, collision_d;
  logic         game_over_q, game_over_d;
  logic [15:0]  score_q, score_d;
  logic [15:0]  ramp_cnt_q, ramp_cnt_d;
  logic [24:0]  move_div_q, move_div_d;
  logic [24:0]  period_q, period_d;
  logic [24:0]  move_cnt_q, move_cnt_d;
  logic [24:0]  spawn_cnt_q, spawn_cnt_d;
  logic [7:0]   lfsr_q, lfsr_d;

  logic         spawn_tick, move_tick, hit, slot_upd, free_found, spawn_ok;
  logic [2:0]   free_idx;
  logic [1:0]   spawn_lane, player_lane_c;
  logic [9:0]   spawn_x, player_x;
  int           exit_cnt, score_sum;

  // Ticks, spawn lane, player position, hit detection and free-slot search.
  always_comb begin
    spawn_tick = (spawn_cnt_q == 25'(SPAWN_DIV - 1));
    // period_q is the divider captured at the last wrap, so a ramp never
    // cuts short a count already in progress.
    move_tick  = (move_cnt_q == period_q - 25'd1);

    if (int'(lfsr_q[1:0]) >= LANE_COUNT) spawn_lane = 2'(int'(lfsr_q[1:0]) - LANE_COUNT);
    else                                 spawn_lane = lfsr_q[1:0];
    spawn_x = 10'(LANE_X0 + int'(spawn_lane) * LANE_PITCH);

    if (int'(player_lane_i) >= LANE_COUNT) player_lane_c = 2'(LANE_COUNT - 1);
    else                                   player_lane_c = player_lane_i;
    player_x = 10'(LANE_X0 + int'(player_lane_c) * LANE_PITCH);

    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (active_q[i] && x_q[i] == player_x &&
          int'(y_q[i]) + CAR_H > PLAYER_Y && int'(y_q[i]) < PLAYER_Y + CAR_H)
        hit = 1'b1;
    end

    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  // Next state. A hit suppresses every slot/score/ramp update in its own
  // cycle, so a hit and an exit of the same slot never score.
  always_comb begin
    slot_upd    = !game_over_q && !hit;
    spawn_ok    = slot_upd && spawn_tick && free_found;
    collision_d = hit && !game_over_q;
    game_over_d = game_over_q || hit;
    active_d    = active_q;
    exit_cnt    = 0;

    for (int i = 0; i < N; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (slot_upd) begin
        if (active_q[i] && int'(y_q[i]) >= Y_END) begin
          active_d[i] = 1'b0;
          y_d[i]      = 10'd0;
          exit_cnt    = exit_cnt + 1;
        end else if (active_q[i] && move_tick) begin
          y_d[i] = y_q[i] + 10'd1;
        end else if (spawn_ok && int'(free_idx) == i) begin
          active_d[i] = 1'b1;
          y_d[i]      = 10'd0;
          x_d[i]      = spawn_x;
        end
      end
    end

    score_sum = int'(score_q) + exit_cnt;
    score_d   = (score_sum > 65535) ? 16'hFFFF : 16'(score_sum);

    ramp_cnt_d = ramp_cnt_q;
    move_div_d = move_div_q;
    if (spawn_ok) begin
      if (int'(ramp_cnt_q) + 1 >= RAMP_SPAWNS) begin
        ramp_cnt_d = 16'd0;
        if (int'(move_div_q) >= MOVE_DIV_MIN + MOVE_DIV_STEP)
          move_div_d = move_div_q - 25'(MOVE_DIV_STEP);
        else
          move_div_d = 25'(MOVE_DIV_MIN);
      end else begin
        ramp_cnt_d = ramp_cnt_q + 16'd1;
      end
    end

    spawn_cnt_d = spawn_cnt_q;
    move_cnt_d  = move_cnt_q;
    period_d    = period_q;
    lfsr_d      = lfsr_q;
    if (!game_over_q) begin
      spawn_cnt_d = spawn_tick ? 25'd0 : spawn_cnt_q + 25'd1;
      if (move_tick) begin
        move_cnt_d = 25'd0;
        period_d   = move_div_d;
      end else begin
        move_cnt_d = move_cnt_q + 25'd1;
      end
      // Fibonacci taps 8,6,5,4
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < N; i++) begin
        x_q[i] <= 10'd0;
        y_q[i] <= 10'd0;
      end
      active_q    <= '0;
      collision_q <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= 16'd0;
      ramp_cnt_q  <= 16'd0;
      move_div_q  <= 25'(MOVE_DIV_INIT);
      period_q    <= 25'(MOVE_DIV_INIT);
      move_cnt_q  <= 25'd0;
      spawn_cnt_q <= 25'd0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      for (int i = 0; i < N; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      active_q    <= active_d;
      collision_q <= collision_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      ramp_cnt_q  <= ramp_cnt_d;
      move_div_q  <= move_div_d;
      period_q    <= period_d;
      move_cnt_q  <= move_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      lfsr_q      <= lfsr_d;
    end
  end

  always_comb begin
    enemy_x_o = '0;
    enemy_y_o = '0;
    for (int i = 0; i < N; i++) begin
      enemy_x_o[10*i +: 10] = x_q[i];
      enemy_y_o[10*i +: 10] = y_q[i];
    end
  end

  assign enemy_active_o = active_q;
  assign collision_o    = collision_q;
  assign game_over_o    = game_over_q;
  assign score_o        = score_q;
  assign move_div_o     = move_div_q;

endmodule

// File: tb/tb_race_enemy_scheduler.sv
// tb/tb_race_enemy_scheduler.sv - self-checking bench for race_enemy_scheduler
module tb_race_enemy_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] pl_a = 2'd0, pl_bc = 2'd0, pl_d = 2'd0;

  logic [39:0] x_a, y_a;  logic [3:0] act_a; logic coll_a, go_a; logic [15:0] score_a; logic [24:0] md_a;
  logic [79:0] x_b, y_b;  logic [7:0] act_b; logic coll_b, go_b; logic [15:0] score_b; logic [24:0] md_b;
  logic [39:0] x_c, y_c;  logic [3:0] act_c; logic coll_c, go_c; logic [15:0] score_c; logic [24:0] md_c;
  logic [9:0]  x_d, y_d;  logic [0:0] act_d; logic coll_d, go_d; logic [15:0] score_d; logic [24:0] md_d;

  // A: main engine, fast ticks, gentle ramp
  race_enemy_scheduler #(.NUM_ENEMIES(4), .SPAWN_DIV(16), .MOVE_DIV_INIT(4), .MOVE_DIV_MIN(2),
    .MOVE_DIV_STEP(1), .RAMP_SPAWNS(3)) dut_a (
    .clk_i(clk), .reset_i(rst), .player_lane_i(pl_a), .enemy_x_o(x_a), .enemy_y_o(y_a),
    .enemy_active_o(act_a), .collision_o(coll_a), .game_over_o(go_a), .score_o(score_a), .move_div_o(md_a));
  // B: ramp to the floor
  race_enemy_scheduler #(.NUM_ENEMIES(8), .SPAWN_DIV(16), .MOVE_DIV_INIT(5000), .MOVE_DIV_MIN(2500),
    .MOVE_DIV_STEP(1000), .RAMP_SPAWNS(2), .Y_END(1000)) dut_b (
    .clk_i(clk), .reset_i(rst), .player_lane_i(pl_bc), .enemy_x_o(x_b), .enemy_y_o(y_b),
    .enemy_active_o(act_b), .collision_o(coll_b), .game_over_o(go_b), .score_o(score_b), .move_div_o(md_b));
  // C: full slots, dropped spawn must not ramp
  race_enemy_scheduler #(.NUM_ENEMIES(4), .SPAWN_DIV(16), .MOVE_DIV_INIT(5000), .MOVE_DIV_MIN(1000),
    .MOVE_DIV_STEP(1000), .RAMP_SPAWNS(5), .Y_END(1000)) dut_c (
    .clk_i(clk), .reset_i(rst), .player_lane_i(pl_bc), .enemy_x_o(x_c), .enemy_y_o(y_c),
    .enemy_active_o(act_c), .collision_o(coll_c), .game_over_o(go_c), .score_o(score_c), .move_div_o(md_c));
  // D: single slot, exit and reuse
  race_enemy_scheduler #(.NUM_ENEMIES(1), .SPAWN_DIV(16), .MOVE_DIV_INIT(4), .MOVE_DIV_MIN(2),
    .MOVE_DIV_STEP(1), .RAMP_SPAWNS(3)) dut_d (
    .clk_i(clk), .reset_i(rst), .player_lane_i(pl_d), .enemy_x_o(x_d), .enemy_y_o(y_d),
    .enemy_active_o(act_d), .collision_o(coll_d), .game_over_o(go_d), .score_o(score_d), .move_div_o(md_d));

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
    logic [7:0] l;
    l = s;
    for (int k = 0; k < n; k++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic int lane_of(input logic [7:0] l);
    int v;
    v = int'(l[1:0]);
    if (v >= 3) v -= 3;
    return v;
  endfunction

  task automatic check_reset_a(input string tag);
    chk({tag, "_x"}, x_a, 0);       chk({tag, "_y"}, y_a, 0);
    chk({tag, "_act"}, act_a, 0);   chk({tag, "_coll"}, coll_a, 0);
    chk({tag, "_go"}, go_a, 0);     chk({tag, "_score"}, score_a, 0);
    chk({tag, "_md"}, md_a, 4);
  endtask

  // Reference model of engine A (4 slots, 3 lanes, SPAWN_DIV 16, div 4 ramping by 1 to 2 every 3 spawns).
  int m_x[4], m_y[4];
  bit m_act[4];
  logic [7:0] m_lfsr;
  int m_sc, m_mc, m_per, m_md, m_ramp, m_score;
  bit m_go, m_coll;

  task automatic model_step(input bit r, input int pl);
    int px, lane, fr;
    bit hit, sp, mv;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_x[i] = 0; m_y[i] = 0; m_act[i] = 0; end
      m_lfsr = 8'hA5; m_sc = 0; m_mc = 0; m_per = 4; m_md = 4; m_ramp = 0;
      m_score = 0; m_go = 0; m_coll = 0;
      return;
    end
    m_coll = 0;
    if (m_go) return;
    px = 197 + ((pl > 2) ? 2 : pl) * 82;
    hit = 0;
    for (int i = 0; i < 4; i++)
      if (m_act[i] && m_x[i] == px && m_y[i] + 121 > 357 && m_y[i] < 357 + 121) hit = 1;
    sp = (m_sc == 15);
    mv = (m_mc == m_per - 1);
    lane = lane_of(m_lfsr);
    if (hit) begin
      m_coll = 1;
      m_go = 1;
    end else begin
      fr = -1;
      for (int i = 3; i >= 0; i--) if (!m_act[i]) fr = i;
      for (int i = 0; i < 4; i++) begin
        if (m_act[i]) begin
          if (m_y[i] >= 600) begin
            m_act[i] = 0; m_y[i] = 0;
            if (m_score < 65535) m_score++;
          end else if (mv) m_y[i]++;
        end
      end
      if (sp && fr >= 0) begin
        m_act[fr] = 1; m_y[fr] = 0; m_x[fr] = 197 + lane * 82;
        m_ramp++;
        if (m_ramp == 3) begin
          m_ramp = 0;
          m_md = (m_md - 1 < 2) ? 2 : m_md - 1;
        end
      end
    end
    m_sc = sp ? 0 : m_sc + 1;
    if (mv) begin m_mc = 0; m_per = m_md; end
    else m_mc++;
    m_lfsr = lfsr_adv(m_lfsr, 1);
  endtask

  task automatic cmp_model();
    logic [39:0] ex, ey;
    logic [3:0] ea;
    for (int i = 0; i < 4; i++) begin
      ex[10*i +: 10] = 10'(m_x[i]);
      ey[10*i +: 10] = 10'(m_y[i]);
      ea[i] = m_act[i];
    end
    chk("m_active", act_a, ea); chk("m_x", x_a, ex); chk("m_y", y_a, ey);
    chk("m_coll", coll_a, m_coll); chk("m_go", go_a, m_go);
    chk("m_score", score_a, m_score); chk("m_md", md_a, m_md);
  endtask

  typedef struct {
    int         k;
    logic [7:0] b_act;
    int         b_md;
    logic [3:0] c_act;
    int         c_md;
  } ramp_vec_t;

  ramp_vec_t tbl[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int L, exp_x, pulses, fails0, go_cnt;
    bit found, held, stop;
    logic [7:0] l15;

    tbl[0] = '{0, 8'h00, 5000, 4'h0, 5000};
    tbl[1] = '{1, 8'h01, 5000, 4'h1, 5000};
    tbl[2] = '{2, 8'h03, 4000, 4'h3, 5000};
    tbl[3] = '{3, 8'h07, 4000, 4'h7, 5000};
    tbl[4] = '{4, 8'h0F, 3000, 4'hF, 5000};
    tbl[5] = '{5, 8'h1F, 3000, 4'hF, 5000};
    tbl[6] = '{6, 8'h3F, 2500, 4'hF, 5000};
    tbl[7] = '{7, 8'h7F, 2500, 4'hF, 5000};
    tbl[8] = '{8, 8'hFF, 2500, 4'hF, 5000};
    tbl[9] = '{9, 8'hFF, 2500, 4'hF, 5000};

    // Reset and first spawn
    l15 = lfsr_adv(8'hA5, 15);
    L = lane_of(l15);
    exp_x = 197 + L * 82;
    pl_a = 2'd0;
    do_reset();
    check_reset_a("rst");
    chk("rst_md_b", md_b, 5000);
    repeat (15) step();
    chk("pre_spawn_act", act_a, 0);
    step();
    chk("spawn_act", act_a, 4'b0001);
    chk("spawn_x", x_a[9:0], exp_x);
    chk("spawn_y", y_a[9:0], 0);
    repeat (3) step();
    chk("y_before_move", y_a[9:0], 0);
    step();
    chk("y_first_move", y_a[9:0], 1);

    // Collision with the first enemy
    pl_a = 2'(L);
    found = 0;
    for (int c = 0; c < 5000 && !found; c++) begin
      step();
      if (y_a[9:0] == 10'd237) found = 1;
    end
    chk("reach_237", found, 1);
    chk("no_coll_before", coll_a, 0);
    step();
    chk("coll_pulse", coll_a, 1);
    chk("go_set", go_a, 1);
    chk("coll_y", y_a[9:0], 237);
    pulses = 0;
    held = 1;
    repeat (1000) begin
      step();
      pulses += int'(coll_a);
      if (y_a[9:0] != 10'd237 || !go_a) held = 0;
    end
    chk("extra_pulses", pulses, 0);
    chk("crash_hold", held, 1);
    chk("active_ge3", ($countones(act_a) >= 3), 1);
    chk("crash_score", score_a, 0);

    // Reset during game over
    do_reset();
    check_reset_a("midrst");

    // Exit on the single-slot engine with the player elsewhere
    pl_d = 2'((L + 1) % 3);
    found = 0;
    for (int c = 0; c < 5000 && !found; c++) begin
      step();
      if (y_d == 10'd600) found = 1;
    end
    chk("reach_600", found, 1);
    chk("active_at_600", act_d, 1);
    step();
    chk("exit_act", act_d, 0);
    chk("exit_y", y_d, 0);
    chk("exit_score", score_d, 1);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (act_d == 1'b1) found = 1;
    end
    chk("slot_reuse", found, 1);
    chk("reuse_y", y_d, 0);
    chk("no_crash_d", go_d, 0);

    // Ramp and full-slot tables
    do_reset();
    for (int e = 0; e < 10; e++) begin
      while (n_checks >= 0) begin
        // advance to cycle 16k+1 of this entry
        if (tbl[e].k == 0) begin step(); break; end
        repeat ((e == 0) ? 0 : 16) step();
        break;
      end
      chk($sformatf("b_act_k%0d", tbl[e].k), act_b, tbl[e].b_act);
      chk($sformatf("b_md_k%0d", tbl[e].k), md_b, tbl[e].b_md);
      chk($sformatf("c_act_k%0d", tbl[e].k), act_c, tbl[e].c_act);
      chk($sformatf("c_md_k%0d", tbl[e].k), md_c, tbl[e].c_md);
    end
    chk("b_y_still", y_b, 0);

    // Randomised lockstep against the model
    stop = 0;
    for (int run = 0; run < 8 && !stop; run++) begin
      pl_a = 2'($urandom_range(0, 3));
      rst = 1'b1;
      model_step(1, int'(pl_a));
      step();
      rst = 1'b0;
      cmp_model();
      go_cnt = 0;
      for (int c = 0; c < 4000 && !stop; c++) begin
        bit rr;
        if ($urandom_range(0, 63) == 0) pl_a = 2'($urandom_range(0, 3));
        rr = ($urandom_range(0, 2999) == 0);
        rst = rr;
        fails0 = n_checks - n_pass;
        model_step(rr, int'(pl_a));
        step();
        rst = 1'b0;
        cmp_model();
        if (n_checks - n_pass != fails0) stop = 1;
        if (m_go) begin
          go_cnt++;
          if (go_cnt > 20) break;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
